// File: rtl/register_pkg.sv
// Shared defaults and sizing helper for the register_pipe chain.
`timescale 1ns/1ps
package register_pkg;
  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 4;

  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/pipe_stage.sv
// One register slot of the pipe: loads whenever it is empty or its word is leaving.
`timescale 1ns/1ps
module pipe_stage import register_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             dn_ready,
  input  logic             flush,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             up_ready
);
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  assign up_ready  = dn_ready || !valid_q;
  assign out_data  = data_q;
  assign out_valid = valid_q;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (up_ready) begin
      data_d  = in_data;
      valid_d = in_valid;
    end
    if (flush) valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end
endmodule

// File: rtl/register_pipe.sv
// DEPTH-stage bubble-collapsing register pipe with valid/ready at both ends,
// synchronous flush and a registered occupancy count.
`timescale 1ns/1ps
module register_pipe import register_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [WIDTH-1:0]              in_word,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [WIDTH-1:0]              out_word,
  output logic                          out_valid,
  input  logic                          out_ready,
  input  logic                          flush,
  output logic [count_width(DEPTH)-1:0] count
);
  localparam int CW = count_width(DEPTH);

  logic [DEPTH:0][WIDTH-1:0] data_pipe;
  logic [DEPTH:0]            vld_pipe;
  logic [CW-1:0]             count_q, count_d;
  logic                      in_xfer, out_xfer;

  assign data_pipe[0] = in_word;
  assign vld_pipe[0]  = in_valid;

  // Each scope owns its ready wire so the ripple runs through distinct nets.
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic rdy_up, rdy_dn;
    if (i == DEPTH - 1) begin : g_last
      assign rdy_dn = out_ready;
    end else begin : g_mid
      assign rdy_dn = g_stage[i+1].rdy_up;
    end

    pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk      (clk),
      .reset    (reset),
      .in_data  (data_pipe[i]),
      .in_valid (vld_pipe[i]),
      .dn_ready (rdy_dn),
      .flush    (flush),
      .out_data (data_pipe[i+1]),
      .out_valid(vld_pipe[i+1]),
      .up_ready (rdy_up)
    );
  end

  assign in_ready  = g_stage[0].rdy_up && !flush;
  assign out_word  = data_pipe[DEPTH];
  assign out_valid = vld_pipe[DEPTH];
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  assign count     = count_q;

  always_comb begin
    count_d = count_q;
    if (flush)                    count_d = '0;
    else if (in_xfer && !out_xfer) count_d = count_q + CW'(1);
    else if (out_xfer && !in_xfer) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end
endmodule

// File: tb/tb_register_pipe.sv
// Bench for register_pipe: directed vector table, reset corner cases and a
// randomized run against a position-based conveyor model.
`timescale 1ns/1ps
module tb_register_pipe;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [WIDTH-1:0] in_word = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] out_word;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             flush = 1'b0;
  logic [CW-1:0]    count;

  register_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_word(in_word), .in_valid(in_valid),
    .in_ready(in_ready), .out_word(out_word), .out_valid(out_valid),
    .out_ready(out_ready), .flush(flush), .count(count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: ordered list of words with the stage index each one sits in.
  typedef struct { logic [7:0] w; int pos; } ent_t;
  ent_t mq[$];
  bit   mv[$];
  logic m_ir, m_ov;
  logic [7:0] m_ow;
  int   m_cnt;
  logic cur_v, cur_r, cur_f;
  logic [7:0] cur_w;

  function automatic void model_eval();
    mv.delete();
    for (int k = 0; k < mq.size(); k++) begin
      bit m;
      if (k == 0) m = (mq[0].pos < DEPTH - 1) || cur_r;
      else        m = (mq[k-1].pos > mq[k].pos + 1) || mv[k-1];
      mv.push_back(m);
    end
    m_cnt = mq.size();
    m_ov  = (mq.size() > 0) && (mq[0].pos == DEPTH - 1);
    m_ow  = (mq.size() > 0) ? mq[0].w : 8'h00;
    m_ir  = !cur_f && ((mq.size() == 0) || (mq[mq.size()-1].pos > 0) || mv[mv.size()-1]);
  endfunction

  function automatic void model_commit();
    ent_t nq[$];
    ent_t e;
    if (cur_f) begin
      mq.delete();
      return;
    end
    for (int k = 0; k < mq.size(); k++) begin
      e = mq[k];
      if (mv[k]) begin
        if (e.pos != DEPTH - 1) begin
          e.pos = e.pos + 1;
          nq.push_back(e);
        end
      end else begin
        nq.push_back(e);
      end
    end
    if (cur_v && m_ir) begin
      e.w = cur_w;
      e.pos = 0;
      nq.push_back(e);
    end
    mq = nq;
  endfunction

  task automatic step_pre(input logic v, input logic [7:0] w, input logic r, input logic f);
    @(negedge clk);
    cur_v = v; cur_w = w; cur_r = r; cur_f = f;
    in_valid = v; in_word = w; out_ready = r; flush = f;
    #4;
    model_eval();
    chk("model_out_valid", out_valid, m_ov);
    chk("model_count", count, m_cnt);
    chk("model_in_ready", in_ready, m_ir);
    if (m_ov) chk("model_out_word", out_word, m_ow);
  endtask

  task automatic step_post();
    @(posedge clk);
    model_commit();
  endtask

  task automatic step(input logic v, input logic [7:0] w, input logic r, input logic f);
    step_pre(v, w, r, f);
    step_post();
  endtask

  typedef struct {
    logic v; logic [7:0] w; logic r; logic f;
    logic eov; logic [7:0] eow; logic eir; int ecnt;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input logic v, input logic [7:0] w, input logic r, input logic f,
                              input logic eov, input logic [7:0] eow, input logic eir, input int ecnt);
    vec_t t;
    t.v = v; t.w = w; t.r = r; t.f = f;
    t.eov = eov; t.eow = eow; t.eir = eir; t.ecnt = ecnt;
    tbl.push_back(t);
  endfunction

  initial begin
    // Stream of four words, consumer always ready.
    add(1, 8'h01, 1, 0, 0, 8'h00, 1, 0);
    add(1, 8'h02, 1, 0, 0, 8'h00, 1, 1);
    add(1, 8'hFF, 1, 0, 0, 8'h00, 1, 2);
    add(1, 8'hAF, 1, 0, 0, 8'h00, 1, 3);
    add(0, 8'h00, 1, 0, 1, 8'h01, 1, 4);
    add(0, 8'h00, 1, 0, 1, 8'h02, 1, 3);
    add(0, 8'h00, 1, 0, 1, 8'hFF, 1, 2);
    add(0, 8'h00, 1, 0, 1, 8'hAF, 1, 1);
    add(0, 8'h00, 1, 0, 0, 8'h00, 1, 0);
    // Back-pressure: fifth word waits for the consumer.
    add(1, 8'h10, 0, 0, 0, 8'h00, 1, 0);
    add(1, 8'h11, 0, 0, 0, 8'h00, 1, 1);
    add(1, 8'h12, 0, 0, 0, 8'h00, 1, 2);
    add(1, 8'h13, 0, 0, 0, 8'h00, 1, 3);
    add(1, 8'h14, 0, 0, 1, 8'h10, 0, 4);
    add(1, 8'h14, 1, 0, 1, 8'h10, 1, 4);
    add(0, 8'h00, 1, 0, 1, 8'h11, 1, 4);
    add(0, 8'h00, 1, 0, 1, 8'h12, 1, 3);
    add(0, 8'h00, 1, 0, 1, 8'h13, 1, 2);
    add(0, 8'h00, 1, 0, 1, 8'h14, 1, 1);
    add(0, 8'h00, 1, 0, 0, 8'h00, 1, 0);
    // Full pipe with simultaneous in/out for three cycles.
    add(1, 8'h20, 0, 0, 0, 8'h00, 1, 0);
    add(1, 8'h21, 0, 0, 0, 8'h00, 1, 1);
    add(1, 8'h22, 0, 0, 0, 8'h00, 1, 2);
    add(1, 8'h23, 0, 0, 0, 8'h00, 1, 3);
    add(1, 8'h24, 1, 0, 1, 8'h20, 1, 4);
    add(1, 8'h25, 1, 0, 1, 8'h21, 1, 4);
    add(1, 8'h26, 1, 0, 1, 8'h22, 1, 4);
    add(0, 8'h00, 1, 0, 1, 8'h23, 1, 4);
    add(0, 8'h00, 1, 0, 1, 8'h24, 1, 3);
    add(0, 8'h00, 1, 0, 1, 8'h25, 1, 2);
    add(0, 8'h00, 1, 0, 1, 8'h26, 1, 1);
    add(0, 8'h00, 1, 0, 0, 8'h00, 1, 0);
    // Flush with a concurrent input beat that must be dropped.
    add(1, 8'h30, 0, 0, 0, 8'h00, 1, 0);
    add(1, 8'h31, 0, 0, 0, 8'h00, 1, 1);
    add(1, 8'h32, 0, 0, 0, 8'h00, 1, 2);
    add(1, 8'hEE, 0, 1, 0, 8'h00, 0, 3);
    for (int k = 0; k < 5; k++) add(0, 8'h00, 1, 0, 0, 8'h00, 1, 0);

    // Reset state, checked while reset is held.
    #7;
    chk("reset_out_word", out_word, 8'h00);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_count", count, 0);
    chk("reset_in_ready", in_ready, 1'b1);
    #3 reset = 1'b1;

    foreach (tbl[k]) begin
      step_pre(tbl[k].v, tbl[k].w, tbl[k].r, tbl[k].f);
      chk("tbl_out_valid", out_valid, tbl[k].eov);
      chk("tbl_count", count, tbl[k].ecnt);
      chk("tbl_in_ready", in_ready, tbl[k].eir);
      if (tbl[k].eov) chk("tbl_out_word", out_word, tbl[k].eow);
      step_post();
    end

    // Mid-cycle asynchronous reset with two words held.
    step(1, 8'h40, 0, 0);
    step(1, 8'h41, 0, 0);
    in_valid = 1'b0;
    #3 reset = 1'b0;
    mq.delete();
    #1;
    chk("async_rst_out_valid", out_valid, 1'b0);
    chk("async_rst_count", count, 0);
    chk("async_rst_out_word", out_word, 8'h00);
    chk("async_rst_in_ready", in_ready, 1'b1);
    #1 reset = 1'b1;
    step(1, 8'h02, 1, 0);
    for (int k = 0; k < 4; k++) begin
      step_pre(0, 8'h00, 1, 0);
      if (k == 3) begin
        chk("post_rst_lat_valid", out_valid, 1'b1);
        chk("post_rst_lat_word", out_word, 8'h02);
      end else begin
        chk("post_rst_early_valid", out_valid, 1'b0);
      end
      step_post();
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 500; n++) begin
      step(($urandom % 4) != 0, 8'($urandom), ($urandom % 3) != 0, ($urandom % 25) == 0);
    end
    for (int n = 0; n < 8; n++) step(0, 8'h00, 1, 0);
    chk("drain_count", count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/register_pipe.md
# register_pipe

Parametrised successor to the team's fixed 8-bit register: a chain of `DEPTH` `WIDTH`-bit register stages with per-stage valid bits and a valid/ready handshake at both ends. Stages collapse bubbles, so a stage accepts data whenever it is empty or being drained. A synchronous flush and an occupancy count are also provided. It sits between datapath blocks that need fixed latency under normal flow and lossless back-pressure when the consumer stalls.

## Interface
- `WIDTH`, default 8: data word width (≥1).
- `DEPTH`, default 4: number of register stages (≥1).
- `clk`  input  1: sole clock; all state updates on rising edge.
- `reset`  input  1: asynchronous, active-low reset.
- `in_word`  input  WIDTH: data offered by producer.
- `in_valid`  input  1: producer has a word on `in_word`.
- `in_ready`  output  1: stage 0 can accept this cycle.
- `out_word`  output  WIDTH: data in last stage (`DEPTH-1`).
- `out_valid`  output  1: last stage holds a valid word.
- `out_ready`  input  1: consumer accepts `out_word` this cycle.
- `flush`  input  1: synchronous clear of all valid bits.
- `count`  output  $clog2(DEPTH+1): number of valid stages.

## Operation
- Per stage i: `valid[i]`, `data[i]`. Stage DEPTH-1 drives `out_word`/`out_valid`.
- Stage i "advances" = `valid[i] && ready[i]`, where `ready[DEPTH-1] = out_ready || !valid[DEPTH-1]` and `ready[i] = ready[i+1] || !valid[i]`. `in_ready = ready[0] && !flush`.
- Stage i loads from stage i-1 (stage 0 from `in_word`/`in_valid`) when `ready[i]`; otherwise it holds. A stage that is emptied by advancing and has no incoming valid word clears its valid bit; its data is don't-care but is loaded anyway (no gating needed).
- Input transfer: `in_valid && in_ready`. Output transfer: `out_valid && out_ready`.
- Flush (high at an edge): every `valid[i]` cleared, `count` → 0 next cycle. Any input beat offered in that cycle is dropped; `in_ready` is low while `flush` is high. Data registers are not required to clear.
- `count` is a registered sum of valid bits. Update: +1 on input transfer, −1 on output transfer, unchanged on both or neither. Flush overrides to 0. Never exceeds DEPTH.
- Words leave in exactly the order accepted; no duplication, no loss except on flush.

## Timing
- Reset (`reset` low, immediate, asynchronous): all valid bits 0, all data 0. So `out_word`=0, `out_valid`=0, `count`=0, `in_ready`=1 (unless `flush`).
- Reset release is synchronous in effect: the first load happens on the first rising edge with `reset` high.
- Latency with `out_ready` held high: a word accepted at edge N appears on `out_word` with `out_valid` after edge N+DEPTH-1, i.e. DEPTH cycles from presentation to transfer. Throughput is 1 word/cycle.
- Full (count=DEPTH) with `out_ready`=1: `in_ready`=1, combinationally through the ready chain; simultaneous in/out keeps count at DEPTH.
- Full with `out_ready`=0: `in_ready`=0; state frozen.
- Empty with `in_valid`=0: all outputs stable; `out_valid`=0.
- Reset asserted mid-stream: all held words discarded immediately.
- `out_ready` high while `out_valid` low: no effect.

## Structure
- Package `register_pkg`: `DEFAULT_WIDTH`=8, `DEFAULT_DEPTH`=4, and a function for count width ($clog2(DEPTH+1)).
- One sub-module `pipe_stage` (WIDTH param; ports clk, reset, in data/valid, downstream ready, out data/valid, ready-out, flush), instantiated DEPTH times via generate. The top level holds the chain wiring and the `count` register.

## Test plan
All scenarios use WIDTH=8, DEPTH=4, 10 ns clock.
- Reset low 10 ns then high → `out_word`=8'h00, `out_valid`=0, `count`=0, `in_ready`=1.
- Stream 8'h01, 8'h02, 8'hFF, 8'hAF on consecutive cycles, `out_ready`=1 → outputs in the same order, each 4 cycles after presentation, one per cycle; `count` peaks at 4.
- `out_ready`=0, push 5 words 8'h10–8'h14 → first 4 accepted, `in_ready`=0 on the 5th, `count`=4. Raise `out_ready` → 8'h10..8'h13 out in order, then 8'h14 accepted and delivered.
- Full, `out_ready`=1 and `in_valid`=1 together for 3 cycles → `count` stays 4 and no word is lost.
- Load 3 words, assert `flush` one cycle with `in_valid`=1 (8'hEE) → next cycle `count`=0, `out_valid`=0; 8'hEE never appears at the output.
- Load 2 words then pulse `reset` low mid-cycle → `out_valid`, `count` drop to 0 asynchronously, before the next edge. After release, 8'h02 passes through with latency 4.
